// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display path.
// Holds the BCD digit type, the "all selects off" constant and the
// one-cold select decoder used by the scan controller.
package seg_disp_pkg;

   // One BCD digit; codes 10..15 are carried through untouched.
   typedef logic [3:0] bcd_t;

   // Widest digit bus the select decoder supports.
   localparam int MAX_DIGITS = 32;

   // Active-low selects: all ones means no digit is driven.
   localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

   // Active-low one-cold decode: bit 'sel' low, every other bit high.
   // A select outside 0..n-1 leaves the whole bus off.
   function automatic logic [MAX_DIGITS-1:0] onecold(input int unsigned sel,
                                                     input int unsigned n);
      logic [MAX_DIGITS-1:0] v;
      v = DIGIT_OFF;
      for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
         if ((k == sel) && (k < n)) begin
            v[k] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/bcd_scan_mux_scan_timer.sv
// Scan timebase for the display multiplexer.
// slot_cnt counts clk cycles inside one digit slot; sel_cnt names the digit
// owning the current slot. frame_end is high in the very last cycle of the
// last slot, which is where the top swaps in newly requested digits.
module scan_timer #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_TICKS = 2**19,
   localparam int SLOT_W       = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1,
   localparam int SEL_W        = $clog2(NUM_DIGITS)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [SLOT_W-1:0] slot_cnt,
   output logic [SEL_W-1:0]  sel_cnt,
   output logic              frame_end
);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_TICKS - 1);
   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

   logic slot_last;
   logic sel_last;

   assign slot_last = (slot_cnt == SLOT_LAST);
   assign sel_last  = (sel_cnt == SEL_LAST);

   // Slot counter wraps every REFRESH_TICKS cycles; each wrap hands the
   // bus to the next digit, and the last digit hands back to digit 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt <= '0;
         sel_cnt  <= '0;
      end else if (slot_last) begin
         slot_cnt <= '0;
         if (sel_last) begin
            sel_cnt <= '0;
         end else begin
            sel_cnt <= sel_cnt + 1'b1;
         end
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // Last cycle of the last slot of the frame.
   assign frame_end = slot_last && sel_last;

endmodule

// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: N-digit time-multiplexed 7-segment scan controller.
// Scans a shadow copy of the BCD digits onto one shared digit bus with an
// active-low one-cold select, inserts dead time at the start of each slot
// to stop ghosting, optionally blanks leading zeros, and only swaps in new
// digits at a frame boundary so a frame never mixes old and new values.
//
// Build option: define DISP_DIM_EN to add the brightness_i port and PWM
// dimming inside each slot. Without it every slot is lit at full duty.
//
// Update protocol: update_i is a one-cycle request with no handshake back.
// Any update_i seen during a frame arms a pending flag; at the last cycle of
// the frame the digits_i/dp_i present in that cycle are captured (a request
// arriving in that same cycle is honoured immediately). Several requests in
// one frame collapse into a single capture.
module bcd_scan_mux
   import seg_disp_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_TICKS = 2**19,
   parameter int BLANK_TICKS   = 64,
   parameter int DIM_BITS      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    update_i,
   input  logic                    lz_blank_i,
`ifdef DISP_DIM_EN
   input  logic [DIM_BITS-1:0]     brightness_i,
`endif
   output logic [3:0]              output_number,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   digit_select,
   output logic                    frame_o
);

   localparam int SLOT_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
   localparam int SEL_W  = $clog2(NUM_DIGITS);

   // First slot cycle in which a digit may be driven.
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_TICKS);

   // ------------------------------------------------------------------
   // Timebase
   // ------------------------------------------------------------------
   logic [SLOT_W-1:0] slot_cnt;
   logic [SEL_W-1:0]  sel_cnt;
   logic              frame_end;

   scan_timer #(
      .NUM_DIGITS    (NUM_DIGITS),
      .REFRESH_TICKS (REFRESH_TICKS)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .slot_cnt  (slot_cnt),
      .sel_cnt   (sel_cnt),
      .frame_end (frame_end)
   );

   // ------------------------------------------------------------------
   // Shadow registers and frame-synchronous capture
   // ------------------------------------------------------------------
   logic [4*NUM_DIGITS-1:0] shadow_dig;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    pending;

   // Capture at frame end when requested; otherwise remember the request.
   // Reset drops any outstanding request along with the shadow contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_dig <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
      end else if (frame_end && (pending || update_i)) begin
         shadow_dig <= digits_i;
         shadow_dp  <= dp_i;
         pending    <= 1'b0;
      end else if (update_i) begin
         pending    <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Digit view of the shadow register
   // ------------------------------------------------------------------
   bcd_t dig_arr [NUM_DIGITS];

   // Unpack the shadow into one BCD value per digit position.
   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         dig_arr[k] = shadow_dig[4*k +: 4];
      end
   end

   // ------------------------------------------------------------------
   // Leading-zero blanking
   // ------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] blank_vec;

   // Walk from the most significant digit down; a digit is a leading zero
   // while it and everything above it is zero. Digit 0 always stays visible
   // so a zero value still shows a single "0". Codes 10..15 count as nonzero.
   always_comb begin
      logic all_zero;
      all_zero  = 1'b1;
      blank_vec = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero     = all_zero && (dig_arr[k] == 4'd0);
         blank_vec[k] = lz_blank_i && all_zero;
      end
   end

   logic blank_sel;
   assign blank_sel = blank_vec[sel_cnt];

   // ------------------------------------------------------------------
   // Brightness (PWM within the slot)
   // ------------------------------------------------------------------
   logic [DIM_BITS-1:0] duty;
   logic                dim_on;

`ifdef DISP_DIM_EN
   assign duty = brightness_i;
`else
   // Full duty: every low-bit pattern of slot_cnt is within range.
   assign duty = '1;
`endif

   // Lit while the low slot bits are within the duty window; all ones means
   // the window covers the whole period.
   assign dim_on = (slot_cnt[DIM_BITS-1:0] <= duty);

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   logic                  lit;
   logic [MAX_DIGITS-1:0] sel_mask;

   // The selected digit drives only after the dead time, when not blanked
   // and inside the duty window.
   assign lit = (slot_cnt >= BLANK_END) && !blank_sel && dim_on;

   // Turn the active digit on by pulling its select low; all others stay off.
   always_comb begin
      sel_mask     = onecold(32'(sel_cnt), NUM_DIGITS);
      digit_select = DIGIT_OFF[NUM_DIGITS-1:0];
      if (lit) begin
         digit_select = sel_mask[NUM_DIGITS-1:0];
      end
   end

   // Digit value passes through even when blanked; the decimal point is
   // suppressed on a blanked digit so no stray dot appears.
   assign output_number = dig_arr[sel_cnt];
   assign dp_o          = shadow_dp[sel_cnt] && !blank_sel;
   assign frame_o       = frame_end;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Self-checking bench for bcd_scan_mux with NUM_DIGITS=4, REFRESH_TICKS=8,
// BLANK_TICKS=2, DIM_BITS=2. A frame is 32 cycles; t counts clk edges since
// the scan position was last at digit 0 / slot 0.
module tb_bcd_scan_mux;

   localparam int ND = 4;
   localparam int RT = 8;
   localparam int BT = 2;
   localparam int DB = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits_i = '0;
   logic [3:0]  dp_i = '0;
   logic        update_i = 1'b0;
   logic        lz_blank_i = 1'b0;
`ifdef DISP_DIM_EN
   logic [DB-1:0] brightness_i = 2'd3;
`endif
   logic [DB-1:0] br_now = 2'd3;

   logic [3:0] output_number;
   logic       dp_o;
   logic [3:0] digit_select;
   logic       frame_o;

   always #5 clk = ~clk;

   bcd_scan_mux #(
      .NUM_DIGITS    (ND),
      .REFRESH_TICKS (RT),
      .BLANK_TICKS   (BT),
      .DIM_BITS      (DB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .digits_i      (digits_i),
      .dp_i          (dp_i),
      .update_i      (update_i),
      .lz_blank_i    (lz_blank_i),
`ifdef DISP_DIM_EN
      .brightness_i  (brightness_i),
`endif
      .output_number (output_number),
      .dp_o          (dp_o),
      .digit_select  (digit_select),
      .frame_o       (frame_o)
   );

   int t;
   int n_cmp;
   int n_fail;

   // ---------------- driver ----------------
   // Advance one clock; outputs are sampled 2 ns after the edge.
   task automatic tick();
      logic r;
      r = reset;
      @(posedge clk);
      #2;
      t = r ? 0 : t + 1;
   endtask

   // ---------------- expected-value model ----------------
   // Packed {digit_select, output_number, dp_o, frame_o} for a given shadow.
   function automatic logic [9:0] model(input logic [15:0] dig, input logic [3:0] dp,
                                        input logic lz, input logic [1:0] br, input int tt);
      int          sel;
      int          slot;
      logic [15:0] upper;
      logic        blank;
      logic        lit;
      logic [3:0]  sv;
      logic [3:0]  num;
      sel   = (tt / RT) % ND;
      slot  = tt % RT;
      upper = dig >> (4 * sel);
      blank = lz && (sel > 0) && (upper == 16'd0);
      lit   = (slot >= BT) && !blank && ((slot % 4) <= int'(br));
      sv    = 4'b1111;
      if (lit) sv[sel] = 1'b0;
      num   = dig[4*sel +: 4];
      return {sv, num, dp[sel] & ~blank, (tt % (RT * ND)) == (RT * ND - 1)};
   endfunction

   function automatic logic [9:0] observed();
      return {digit_select, output_number, dp_o, frame_o};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [9:0] obs;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         obs = observed();
         n_cmp++;
         if (obs !== 10'b1111_0000_0_0) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got %b want %b (sel,num,dp,frame)", i, obs, 10'b1111_0000_0_0);
         end
      end
      reset = 1'b0;
      tick();
      obs = observed();
      n_cmp++;
      if (obs !== 10'b1111_0000_0_0) begin
         n_fail++;
         $display("FAIL reset_rel1 got %b want %b", obs, 10'b1111_0000_0_0);
      end
      tick();
      obs = observed();
      n_cmp++;
      if (obs !== 10'b1110_0000_0_0) begin
         n_fail++;
         $display("FAIL reset_rel2 got %b want %b", obs, 10'b1110_0000_0_0);
      end
   endtask

   task automatic test_update();
      logic [9:0] obs;
      logic [9:0] exp;
      int lit_cnt[4];
      int frames;
      for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
      frames   = 0;
      digits_i = 16'h4321;
      dp_i     = 4'b0101;
      update_i = 1'b1;
      while (t < 64) begin
         tick();
         update_i = 1'b0;
         obs = observed();
         exp = (t >= 32) ? model(16'h4321, 4'b0101, 1'b0, br_now, t)
                         : model(16'h0000, 4'b0000, 1'b0, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL update t=%0d got %b want %b", t, obs, exp);
         end
         if (t >= 32) begin
            for (int k = 0; k < 4; k++) if (digit_select[k] == 1'b0) lit_cnt[k]++;
            if (frame_o) frames++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (lit_cnt[k] !== 6) begin
            n_fail++;
            $display("FAIL lit_count digit=%0d got %0d want 6", k, lit_cnt[k]);
         end
      end
      n_cmp++;
      if (frames !== 1) begin
         n_fail++;
         $display("FAIL frame_count got %0d want 1", frames);
      end
   endtask

   task automatic test_mid_frame_update();
      logic [9:0] obs;
      logic [9:0] exp;
      while (t < 160) begin
         tick();
         update_i = 1'b0;
         obs = observed();
         if (t < 96)       exp = model(16'h4321, 4'b0101, 1'b0, br_now, t);
         else if (t < 128) exp = model(16'h9876, 4'b0101, 1'b0, br_now, t);
         else              exp = model(16'h1357, 4'b0101, 1'b0, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_frame t=%0d got %b want %b", t, obs, exp);
         end
         if (t == 75) begin
            digits_i = 16'h9876;
            update_i = 1'b1;
         end
         if (t == 127) begin
            digits_i = 16'h1357;
            update_i = 1'b1;
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [9:0] obs;
      logic [9:0] exp;
      digits_i = 16'h0050;
      dp_i     = 4'b1000;
      update_i = 1'b1;
      while (t < 319) begin
         tick();
         update_i = 1'b0;
         obs = observed();
         if (t < 192)      exp = model(16'h1357, 4'b0101, 1'b0, br_now, t);
         else if (t < 224) exp = model(16'h0050, 4'b1000, 1'b0, br_now, t);
         else if (t < 256) exp = model(16'h0050, 4'b1000, 1'b1, br_now, t);
         else if (t < 288) exp = model(16'h0000, 4'b1000, 1'b1, br_now, t);
         else              exp = model(16'h0A00, 4'b1000, 1'b1, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL lz_blank t=%0d got %b want %b", t, obs, exp);
         end
         if (t == 223) lz_blank_i = 1'b1;
         if (t == 224) begin
            digits_i = 16'h0000;
            update_i = 1'b1;
         end
         if (t == 256 || t == 270) begin
            digits_i = 16'h0A00;
            update_i = 1'b1;
         end
      end
      lz_blank_i = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] obs;
      logic [9:0] exp;
      for (int i = 0; i < 22; i++) begin
         tick();
         update_i = 1'b0;
         obs = observed();
         exp = model(16'h0A00, 4'b1000, 1'b0, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL pre_reset t=%0d got %b want %b", t, obs, exp);
         end
         if (t == 325) begin
            digits_i = 16'h2222;
            dp_i     = 4'b1111;
            update_i = 1'b1;
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      obs = observed();
      n_cmp++;
      if (obs !== 10'b1111_0000_0_0) begin
         n_fail++;
         $display("FAIL reset_abort got %b want %b", obs, 10'b1111_0000_0_0);
      end
      while (t < 47) begin
         tick();
         obs = observed();
         exp = model(16'h0000, 4'b0000, 1'b0, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL no_capture t=%0d got %b want %b", t, obs, exp);
         end
      end
   endtask

   task automatic test_dim();
      logic [9:0] obs;
      logic [9:0] exp;
      int lit;
      int want;
`ifdef DISP_DIM_EN
      br_now       = 2'd1;
      brightness_i = 2'd1;
      lit = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         obs = observed();
         exp = model(16'h0000, 4'b0000, 1'b0, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL dim1 t=%0d got %b want %b", t, obs, exp);
         end
         if (digit_select != 4'b1111) lit++;
      end
      n_cmp++;
      if (lit !== 2) begin
         n_fail++;
         $display("FAIL dim1_count got %0d want 2", lit);
      end
      br_now       = 2'd3;
      brightness_i = 2'd3;
`else
      repeat (8) tick();
`endif
      want = 6;
      lit  = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         obs = observed();
         exp = model(16'h0000, 4'b0000, 1'b0, br_now, t);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL dim3 t=%0d got %b want %b", t, obs, exp);
         end
         if (digit_select != 4'b1111) lit++;
      end
      n_cmp++;
      if (lit !== want) begin
         n_fail++;
         $display("FAIL dim3_count got %0d want %0d", lit, want);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      t      = 0;
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_update();
      test_mid_frame_update();
      test_lz_blank();
      test_reset_mid_frame();
      test_dim();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
